mem_bist: RTL

//  Memory built-in self-test initiator for the data memory port. It drives the same
//  ce/we/addr/wdata/rdata interface the core uses, from the bus-master side. Runs a
//  4-phase march (write P, read/compare P, write ~P, read/compare ~P) over a word range.

---
 rtl/mem_bist_pkg.sv | 21 ++
 rtl/mem_bist_pattern.sv | 19 +
 rtl/mem_bist.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST initiator.
package mem_bist_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_WRI  = 3'd3,
        ST_RDI  = 3'd4,
        ST_DONE = 3'd5
    } bist_state_t;

    // A single-word range still needs a 1-bit index register.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_bist_pattern.sv
// March pattern generator: {index, ~index} in 16-bit halves, optionally inverted.
// Shared by the write-data path and the read-compare path, so both always agree.
module mem_bist_pattern
    import mem_bist_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic [IDX_W-1:0]  i_index,
    input  logic              i_invert,
    output logic [DATA_W-1:0] o_pattern
);

    logic [15:0] w_idx16;

    // Index is zero-extended (or truncated) to 16 bits before forming the halves.
    assign w_idx16   = 16'(i_index);
    assign o_pattern = {w_idx16, ~w_idx16} ^ {DATA_W{i_invert}};

endmodule

// File: rtl/mem_bist.sv
// Memory BIST initiator: 4-phase march (write P, read P, write ~P, read ~P)
// over DEPTH_WORDS words starting at ADDR_BASE. Stops at the first mismatch
// and records its address and read data.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | no test run since reset; memory port quiet
// ST_WR   | writing P(i), one word per cycle
// ST_RD   | reading and comparing against P(i)
// ST_WRI  | writing ~P(i)
// ST_RDI  | reading and comparing against ~P(i)
// ST_DONE | result valid; waits for a new start
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE   = 32'h0,
    parameter int                DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_data_o,
    output logic              data_ce_o,
    output logic              data_we_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_o,
    input  logic [DATA_W-1:0] data_i
);

    localparam int               IDX_W    = idx_width(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    bist_state_t       r_state;
    bist_state_t       w_state_nxt;
    logic [IDX_W-1:0]  r_index;
    logic [IDX_W-1:0]  w_index_nxt;
    logic [IDX_W-1:0]  w_index_inc;
    logic              r_pass;
    logic              w_pass_nxt;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [ADDR_W-1:0] w_fail_addr_nxt;
    logic [DATA_W-1:0] r_fail_data;
    logic [DATA_W-1:0] w_fail_data_nxt;

    logic              w_busy;
    logic              w_write;
    logic              w_read;
    logic              w_invert;
    logic              w_last;
    logic              w_mismatch;
    logic [DATA_W-1:0] w_pattern;
    logic [ADDR_W-1:0] w_addr;

    mem_bist_pattern #(
        .IDX_W (IDX_W)
    ) u_pattern (
        .i_index   (r_index),
        .i_invert  (w_invert),
        .o_pattern (w_pattern)
    );

    // Phase decode, address generation and compare, all from registered state.
    always_comb begin
        w_write     = (r_state == ST_WR)  || (r_state == ST_WRI);
        w_read      = (r_state == ST_RD)  || (r_state == ST_RDI);
        w_invert    = (r_state == ST_WRI) || (r_state == ST_RDI);
        w_busy      = w_write || w_read;
        w_last      = (r_index == LAST_IDX);
        w_index_inc = w_last ? '0 : r_index + IDX_W'(1);
        w_addr      = ADDR_BASE + (ADDR_W'(r_index) << 2);
        w_mismatch  = w_read && (data_i != w_pattern);
    end

    // Moore memory-port outputs; the port is fully quiet outside the march phases.
    always_comb begin
        busy_o      = w_busy;
        done_o      = (r_state == ST_DONE);
        pass_o      = r_pass;
        fail_addr_o = r_fail_addr;
        fail_data_o = r_fail_data;
        data_ce_o   = w_busy;
        data_we_o   = w_write;
        data_addr_o = w_busy  ? w_addr    : '0;
        data_o      = w_write ? w_pattern : '0;
    end

    // Next-state, index and result logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_pass_nxt      = r_pass;
        w_fail_addr_nxt = r_fail_addr;
        w_fail_data_nxt = r_fail_data;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    w_state_nxt     = ST_WR;
                    w_index_nxt     = '0;
                    w_pass_nxt      = 1'b0;
                    w_fail_addr_nxt = '0;
                    w_fail_data_nxt = '0;
                end
            end
            ST_WR, ST_WRI: begin
                w_index_nxt = w_index_inc;
                if (w_last) begin
                    w_state_nxt = (r_state == ST_WR) ? ST_RD : ST_RDI;
                end
            end
            ST_RD, ST_RDI: begin
                if (w_mismatch) begin
                    // First mismatch ends the test; later words are never visited.
                    w_state_nxt     = ST_DONE;
                    w_index_nxt     = '0;
                    w_pass_nxt      = 1'b0;
                    w_fail_addr_nxt = w_addr;
                    w_fail_data_nxt = data_i;
                end else begin
                    w_index_nxt = w_index_inc;
                    if (w_last) begin
                        if (r_state == ST_RD) begin
                            w_state_nxt = ST_WRI;
                        end else begin
                            w_state_nxt = ST_DONE;
                            w_pass_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_index_nxt = '0;
            end
        endcase
    end

    // State and result registers; reset aborts any test in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_index     <= w_index_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_addr <= w_fail_addr_nxt;
            r_fail_data <= w_fail_data_nxt;
        end
    end

endmodule
